// File: rtl/dsp_audio_pkg.sv
// Shared audio definitions for the S-DSP output path: frame timing constants,
// the stereo sample pair and the I2S word-select helper.
package dsp_audio_pkg;

    localparam int unsigned SAMPLE_WIDTH     = 16;
    localparam int unsigned CLOCKS_PER_FRAME = 4 * SAMPLE_WIDTH;
    localparam int unsigned FRAME_LOAD_CYC   = CLOCKS_PER_FRAME - 1;
    localparam int unsigned CYC_WIDTH        = $clog2(CLOCKS_PER_FRAME);
    localparam int unsigned SLOT_WIDTH       = CYC_WIDTH - 1;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] l;
        logic [SAMPLE_WIDTH-1:0] r;
    } stereo_sample_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

    // Word select is judged on the following slot so LRCK leads the MSB by one bit.
    function automatic channel_t slot_channel(input logic [SLOT_WIDTH-1:0] slot);
        logic [SLOT_WIDTH-1:0] next_slot;
        next_slot = slot + 1'b1;
        return next_slot[SLOT_WIDTH-1] ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage

// File: rtl/dsp_sample_fifo.sv
// Small synchronous FIFO for stereo pairs; a pop and a push in the same cycle
// are resolved pop-first so a full FIFO can still accept the incoming word.
module dsp_sample_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned LW = $clog2(DEPTH + 1),
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [LW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        empty    = (count == '0);
        full     = (count == LW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
        level    = count;
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/dsp_i2s_tx.sv
// I2S transmitter for the S-DSP stereo output: buffers {L,R} pairs and
// serialises one pair per 64-clock frame, MSB first with a one-bit LRCK lead.
module dsp_i2s_tx #(
    parameter int unsigned SAMPLE_WIDTH     = dsp_audio_pkg::SAMPLE_WIDTH,
    parameter int unsigned FIFO_DEPTH       = 2,
    parameter int unsigned CLOCKS_PER_FRAME = dsp_audio_pkg::CLOCKS_PER_FRAME
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]           sample_l,
    input  logic [SAMPLE_WIDTH-1:0]           sample_r,
    input  logic                              clear_flags,
    output logic                              i2s_bclk,
    output logic                              i2s_lrck,
    output logic                              i2s_sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              underrun,
    output logic                              overflow
);

    import dsp_audio_pkg::*;

    localparam logic [SLOT_WIDTH-1:0] SLOT_MSB = '1;

    logic [CYC_WIDTH-1:0]  cyc;
    logic [SLOT_WIDTH-1:0] slot;
    logic                  frame_load;
    logic                  primed;
    stereo_sample_t        shift;
    stereo_sample_t        push_pair;
    stereo_sample_t        pop_pair;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  push_taken;
    logic                  underrun_set;
    logic                  overflow_set;

    always_comb begin
        slot         = cyc[CYC_WIDTH-1:1];
        frame_load   = enable && (cyc == CYC_WIDTH'(FRAME_LOAD_CYC));
        fifo_pop     = frame_load && !fifo_empty;
        push_pair    = '{l: sample_l, r: sample_r};
        push_taken   = enable && sample_valid && (!fifo_full || fifo_pop);
        underrun_set = frame_load && fifo_empty && primed;
        // Full implies non-empty, so a load this cycle always frees a slot.
        overflow_set = enable && sample_valid && fifo_full && !fifo_pop;
    end

    dsp_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(stereo_sample_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (!enable),
        .push      (sample_valid),
        .push_data (push_pair),
        .pop       (fifo_pop),
        .pop_data  (pop_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc       <= '0;
            shift     <= '0;
            primed    <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underrun <= underrun_set || (underrun && !clear_flags);
            overflow <= overflow_set || (overflow && !clear_flags);

            if (!enable) begin
                cyc       <= '0;
                shift     <= '0;
                primed    <= 1'b0;
                i2s_bclk  <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_sdata <= 1'b0;
            end else begin
                cyc       <= cyc + 1'b1;
                i2s_bclk  <= cyc[0];
                i2s_lrck  <= (slot_channel(slot) == CH_RIGHT);
                i2s_sdata <= shift[SLOT_MSB - slot];
                if (frame_load) begin
                    shift <= fifo_empty ? '0 : pop_pair;
                end
                if (push_taken) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_i2s_tx.sv
// Directed bench for dsp_i2s_tx: frame timing, FIFO ordering, sticky flags,
// reset and disable behaviour, each against hand-derived expected values.
module tb_dsp_i2s_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        clear_flags = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic [1:0]  fifo_level;
    logic        underrun;
    logic        overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [5:0]  cyc_tb = '0;

    always #5 clock = ~clock;

    dsp_i2s_tx #(
        .SAMPLE_WIDTH     (16),
        .FIFO_DEPTH       (2),
        .CLOCKS_PER_FRAME (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .clear_flags  (clear_flags),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One clock; cyc_tb tracks the DUT counter value after the edge.
    task automatic step();
        @(posedge clock);
        if (!reset || !enable) cyc_tb = '0;
        else cyc_tb = cyc_tb + 1'b1;
        @(negedge clock);
    endtask

    task automatic run_to(input logic [5:0] target);
        for (int i = 0; i < 70 && cyc_tb != target; i++) step();
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        sample_valid = 1'b1;
        sample_l     = l;
        sample_r     = r;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " bclk"}, 32'(i2s_bclk), 0);
        check_eq({tag, " lrck"}, 32'(i2s_lrck), 0);
        check_eq({tag, " sdata"}, 32'(i2s_sdata), 0);
        check_eq({tag, " level"}, 32'(fifo_level), 0);
        check_eq({tag, " underrun"}, 32'(underrun), 0);
        check_eq({tag, " overflow"}, 32'(overflow), 0);
    endtask

    // Call with the DUT counter at 0 just after a frame load.
    task automatic check_frame(input logic [31:0] word, input string tag);
        int k;
        for (int c = 0; c < 64; c++) begin
            step();
            k = c / 2;
            check_eq($sformatf("%s sdata c%0d", tag, c), 32'(i2s_sdata), 32'(word[31 - k]));
            check_eq($sformatf("%s lrck c%0d", tag, c), 32'(i2s_lrck), (k >= 15 && k <= 30) ? 1 : 0);
            check_eq($sformatf("%s bclk c%0d", tag, c), 32'(i2s_bclk), c % 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clock);
        enable = 1'b1;
        repeat (5) step();
        check_all_zero("reset");
        reset = 1'b1;

        // Unprimed: no data, no underrun
        for (int i = 0; i < 200; i++) begin
            step();
            check_eq("idle sdata", 32'(i2s_sdata), 0);
            check_eq("idle underrun", 32'(underrun), 0);
        end
        check_eq("idle level", 32'(fifo_level), 0);
        check_eq("idle overflow", 32'(overflow), 0);

        // Single pair then underrun
        run_to(6'd10);
        push(16'hA55A, 16'h0F0F);
        check_eq("t2 level after push", 32'(fifo_level), 1);
        run_to(6'd0);
        check_eq("t2 level after load", 32'(fifo_level), 0);
        check_eq("t2 underrun before", 32'(underrun), 0);
        check_frame(32'hA55A0F0F, "t2");
        check_eq("t4 underrun set", 32'(underrun), 1);
        check_frame(32'h0, "t4 zero");
        pulse_clear();
        check_eq("t4 underrun cleared", 32'(underrun), 0);

        // Overflow: third push dropped, set wins over simultaneous clear
        run_to(6'd5);
        push(16'h1234, 16'h8001);
        push(16'hFFFF, 16'h0000);
        check_eq("t3 level full", 32'(fifo_level), 2);
        check_eq("t3 overflow before", 32'(overflow), 0);
        clear_flags = 1'b1;
        push(16'hDEAD, 16'hBEEF);
        clear_flags = 1'b0;
        check_eq("t3 overflow set", 32'(overflow), 1);
        check_eq("t3 level kept", 32'(fifo_level), 2);
        run_to(6'd0);
        check_eq("t3 level after load", 32'(fifo_level), 1);
        check_frame(32'h12348001, "t3 p1");
        check_eq("t3 level after p2 load", 32'(fifo_level), 0);
        check_frame(32'hFFFF0000, "t3 p2");
        pulse_clear();
        check_eq("t5 flags cleared ovf", 32'(overflow), 0);
        check_eq("t5 flags cleared unr", 32'(underrun), 0);

        // Push into a full FIFO on the load cycle
        run_to(6'd2);
        push(16'h8000, 16'h7FFF);
        push(16'h0001, 16'hFFFE);
        check_eq("t5 level full", 32'(fifo_level), 2);
        run_to(6'd63);
        push(16'hC3C3, 16'h3C3C);
        check_eq("t5 level at load", 32'(fifo_level), 2);
        check_eq("t5 overflow", 32'(overflow), 0);
        check_frame(32'h80007FFF, "t5 q1");
        check_eq("t5 level after q2 load", 32'(fifo_level), 1);
        check_frame(32'h0001FFFE, "t5 q2");
        check_eq("t5 level after q3 load", 32'(fifo_level), 0);
        check_frame(32'hC3C33C3C, "t5 q3");

        // Reset mid-frame at slot 7
        run_to(6'd2);
        push(16'h1111, 16'h2222);
        check_eq("t6 level before reset", 32'(fifo_level), 1);
        run_to(6'd14);
        reset = 1'b0;
        step();
        check_all_zero("t6 reset");
        step();
        reset = 1'b1;
        run_to(6'd10);
        push(16'h5A5A, 16'hA5A5);
        run_to(6'd0);
        check_eq("t6 underrun", 32'(underrun), 0);
        check_frame(32'h5A5AA5A5, "t6 r2");

        // Disable flushes FIFO and primed, keeps flags
        check_eq("dis underrun pre", 32'(underrun), 1);
        run_to(6'd3);
        push(16'h7777, 16'h8888);
        check_eq("dis level pre", 32'(fifo_level), 1);
        enable = 1'b0;
        step();
        check_eq("dis level", 32'(fifo_level), 0);
        check_eq("dis sdata", 32'(i2s_sdata), 0);
        check_eq("dis bclk", 32'(i2s_bclk), 0);
        check_eq("dis lrck", 32'(i2s_lrck), 0);
        check_eq("dis underrun kept", 32'(underrun), 1);
        step();
        enable = 1'b1;
        pulse_clear();
        run_to(6'd0);
        check_eq("dis unprimed underrun", 32'(underrun), 0);
        check_frame(32'h0, "dis zero");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
